// File: rtl/led_pulse_train_pkg.sv
// ---------------------------------------------------------------------------
// led_pulse_pkg
// Shared types and default constants for the LED pulse-train block.
//   led_state_t  : flash FSM state (IDLE, ON, OFF)
//   DEF_*        : default parameter values used by the modules
//   max_int      : constant helper used to size the tick counter
// ---------------------------------------------------------------------------
package led_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } led_state_t;

    localparam int DEF_TICK_DIV  = 1048576;
    localparam int DEF_ON_TICKS  = 2;
    localparam int DEF_OFF_TICKS = 2;
    localparam int DEF_CNT_W     = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_train_if.sv
// ---------------------------------------------------------------------------
// led_pulse_train_if
// Event/status bundle between an event source and the LED pulse-train block.
//   event_in : single-cycle event strobe (source -> block)
//   led_out  : LED drive (block -> pin)
//   busy     : flash in progress
//   pending  : queued events not yet started (CNT_W bits)
//   overflow : sticky, an event was dropped
// Modports: master = event source / observer, slave = led_pulse_train.
// ---------------------------------------------------------------------------
interface led_pulse_train_if
    import led_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             event_in;
    logic             led_out;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    modport master (
        output event_in,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  event_in,
        output led_out,
        output busy,
        output pending,
        output overflow
    );

endinterface

// File: rtl/led_pulse_train_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides clk into a one-cycle tick every TICK_DIV enabled cycles.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   clear  : restart the count from 0 (phase entry)
//   enable : count only while a flash phase is active
//   tick   : high on the last cycle of each TICK_DIV period
// ---------------------------------------------------------------------------
module tick_prescaler
    import led_pulse_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Clear has priority over counting so a new phase always starts at 0,
    // even when the previous phase ended on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + PW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/led_pulse_train.sv
// ---------------------------------------------------------------------------
// led_pulse_train
// Turns single-cycle event strobes into human-visible LED flashes. Each event
// gives one ON phase (ON_TICKS ticks) followed by an OFF gap (OFF_TICKS
// ticks). Events arriving mid-flash are queued in a saturating counter and
// replayed back-to-back.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : led_pulse_train_if.slave (event_in, led_out, busy, pending,
//           overflow)
// Build option: define LED_PULSE_ACTIVE_LOW_EN for an active-low LED pin
// (led_out = 0 when lit, 1 at reset). Status outputs are unaffected.
// ---------------------------------------------------------------------------
module led_pulse_train
    import led_pulse_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    led_pulse_train_if.slave bus
);

    localparam int               TW        = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);
    localparam logic [TW-1:0]    ON_LAST   = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0]    OFF_LAST  = TW'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

`ifdef LED_PULSE_ACTIVE_LOW_EN
    localparam logic LED_LIT = 1'b0;
`else
    localparam logic LED_LIT = 1'b1;
`endif
    localparam logic LED_DARK = ~LED_LIT;

    led_state_t       state;
    led_state_t       state_next;
    logic             tick;
    logic [TW-1:0]    tick_cnt;
    logic             phase_entry;
    logic             take_direct;
    logic             take_pending;
    logic [CNT_W-1:0] pending_q;
    logic             overflow_q;
    logic             led_q;

    // Every state change is the start of a new phase, so both timing
    // counters restart exactly there.
    assign phase_entry = (state_next != state);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (phase_entry),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. take_direct marks an event that starts a flash by
    // itself and therefore must not be queued; take_pending marks a flash
    // started from the queue.
    always_comb begin
        state_next   = state;
        take_direct  = 1'b0;
        take_pending = 1'b0;
        case (state)
            IDLE: begin
                if (bus.event_in) begin
                    state_next  = ON;
                    take_direct = 1'b1;
                end
            end
            ON: begin
                if (tick && (tick_cnt == ON_LAST)) begin
                    state_next = OFF;
                end
            end
            OFF: begin
                if (tick && (tick_cnt == OFF_LAST)) begin
                    if (pending_q != '0) begin
                        state_next   = ON;
                        take_pending = 1'b1;
                    end else if (bus.event_in) begin
                        state_next  = ON;
                        take_direct = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts ticks within the current phase; a phase always exits on its
    // last tick, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (phase_entry) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Pending queue: a queued event and a replay in the same cycle cancel.
    // At saturation an event is dropped only when no replay frees a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else if (bus.event_in && !take_direct) begin
            if (take_pending) begin
                pending_q <= pending_q;
            end else if (pending_q == PEND_MAX) begin
                overflow_q <= 1'b1;
            end else begin
                pending_q <= pending_q + CNT_W'(1);
            end
        end else if (take_pending) begin
            pending_q <= pending_q - CNT_W'(1);
        end
    end

    // LED drive follows the registered state so it changes on the same edge
    // as the FSM and has no path from event_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= LED_DARK;
        end else begin
            led_q <= (state_next == ON) ? LED_LIT : LED_DARK;
        end
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = (state != IDLE);
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_led_pulse_train.sv
// ---------------------------------------------------------------------------
// tb_led_pulse_train
// Self-checking bench for led_pulse_train with TICK_DIV=4, ON_TICKS=2,
// OFF_TICKS=1, CNT_W=2. Expected flash start cycles go into a queue as each
// event is driven and are popped when a lit phase begins. Honours
// LED_PULSE_ACTIVE_LOW_EN for the LED polarity.
// ---------------------------------------------------------------------------
module tb_led_pulse_train;
    import led_pulse_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;
    localparam int CNT_W     = 2;

    localparam int FLASH_LEN = ON_TICKS * TICK_DIV;
    localparam int GAP_LEN   = OFF_TICKS * TICK_DIV;
    localparam int PERIOD    = FLASH_LEN + GAP_LEN;
    localparam int PEND_CAP  = (1 << CNT_W) - 1;

`ifdef LED_PULSE_ACTIVE_LOW_EN
    localparam logic LED_DARK = 1'b1;
`else
    localparam logic LED_DARK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_pulse_train_if #(.CNT_W(CNT_W)) bus ();

    led_pulse_train #(
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_start[$];

    logic             lit_s;
    logic             busy_s;
    logic             ovf_s;
    logic [CNT_W-1:0] pend_s;

    // One bench cycle: sample the outputs settled from the previous edge,
    // then drive event_in for the current cycle.
    task automatic drive_cycle(input logic ev);
        @(negedge clk);
        lit_s  = bus.led_out ^ LED_DARK;
        busy_s = bus.busy;
        pend_s = bus.pending;
        ovf_s  = bus.overflow;
        bus.event_in = ev;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.event_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.event_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.led_out !== LED_DARK) begin
            failures++;
            $display("[TB] FAIL reset_led got=%b want=%b", bus.led_out, LED_DARK);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.pending !== '0) begin
            failures++;
            $display("[TB] FAIL reset_pending got=%0d want=0", bus.pending);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow);
        end
        reset = 1'b0;
        bus.event_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.led_out !== LED_DARK) begin
            failures++;
            $display("[TB] FAIL reset_release busy=%b led=%b want busy=0 led=%b",
                     bus.busy, bus.led_out, LED_DARK);
        end
    endtask

    task automatic test_single_pulse();
        int   t_rise;
        int   want;
        logic prev;
        do_reset();
        exp_start.delete();
        prev   = 1'b0;
        t_rise = 0;
        for (int t = 0; t < 30; t++) begin
            drive_cycle(t == 10);
            if (t == 10) exp_start.push_back(t + 1);
            if (lit_s === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (exp_start.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL s1_start unexpected flash at t=%0d", t);
                end else begin
                    want = exp_start.pop_front();
                    if (t !== want) begin
                        failures++;
                        $display("[TB] FAIL s1_start got=%0d want=%0d", t, want);
                    end
                end
                t_rise = t;
            end
            if (lit_s !== 1'b1 && prev === 1'b1) begin
                checks++;
                if (t - t_rise !== FLASH_LEN) begin
                    failures++;
                    $display("[TB] FAIL s1_len got=%0d want=%0d", t - t_rise, FLASH_LEN);
                end
            end
            prev = lit_s;
            if (t == 10 + FLASH_LEN + GAP_LEN) begin
                checks++;
                if (busy_s !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL s1_busy_gap got=%b want=1", busy_s);
                end
            end
            if (t == 11 + FLASH_LEN + GAP_LEN) begin
                checks++;
                if (busy_s !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL s1_busy_end got=%b want=0", busy_s);
                end
            end
            if (t == 15) begin
                checks++;
                if (pend_s !== '0) begin
                    failures++;
                    $display("[TB] FAIL s1_pending got=%0d want=0", pend_s);
                end
            end
        end
        checks++;
        if (exp_start.size() != 0) begin
            failures++;
            $display("[TB] FAIL s1_count missing=%0d want=0", exp_start.size());
        end
    endtask

    task automatic test_queue();
        int   t_rise;
        int   want;
        int   n_ev;
        logic prev;
        logic ev;
        do_reset();
        exp_start.delete();
        prev   = 1'b0;
        t_rise = 0;
        n_ev   = 0;
        for (int t = 0; t < 52; t++) begin
            ev = (t == 10) || (t == 12) || (t == 14);
            drive_cycle(ev);
            if (ev) begin
                exp_start.push_back(11 + n_ev * PERIOD);
                n_ev++;
            end
            if (lit_s === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (exp_start.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL s2_start unexpected flash at t=%0d", t);
                end else begin
                    want = exp_start.pop_front();
                    if (t !== want) begin
                        failures++;
                        $display("[TB] FAIL s2_start got=%0d want=%0d", t, want);
                    end
                end
                t_rise = t;
            end
            if (lit_s !== 1'b1 && prev === 1'b1) begin
                checks++;
                if (t - t_rise !== FLASH_LEN) begin
                    failures++;
                    $display("[TB] FAIL s2_len got=%0d want=%0d", t - t_rise, FLASH_LEN);
                end
            end
            prev = lit_s;
            if (t == 15) begin
                checks++;
                if (pend_s !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL s2_pending_peak got=%0d want=2", pend_s);
                end
            end
            if (t == 23) begin
                checks++;
                if (pend_s !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL s2_pending_mid got=%0d want=1", pend_s);
                end
            end
            if (t == 47) begin
                checks++;
                if (pend_s !== '0 || busy_s !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL s2_end pending=%0d busy=%b want 0/0", pend_s, busy_s);
                end
            end
        end
        checks++;
        if (exp_start.size() != 0) begin
            failures++;
            $display("[TB] FAIL s2_count missing=%0d want=0", exp_start.size());
        end
    endtask

    task automatic test_overflow();
        int   t_rise;
        int   want;
        int   n_acc;
        logic prev;
        logic ev;
        do_reset();
        exp_start.delete();
        prev   = 1'b0;
        t_rise = 0;
        n_acc  = 0;
        for (int t = 0; t < 64; t++) begin
            ev = (t == 10) || (t >= 12 && t <= 17);
            drive_cycle(ev);
            if (ev) begin
                if (n_acc < 1 + PEND_CAP) exp_start.push_back(11 + n_acc * PERIOD);
                n_acc++;
            end
            if (lit_s === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (exp_start.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL s3_start unexpected flash at t=%0d", t);
                end else begin
                    want = exp_start.pop_front();
                    if (t !== want) begin
                        failures++;
                        $display("[TB] FAIL s3_start got=%0d want=%0d", t, want);
                    end
                end
                t_rise = t;
            end
            if (lit_s !== 1'b1 && prev === 1'b1) begin
                checks++;
                if (t - t_rise !== FLASH_LEN) begin
                    failures++;
                    $display("[TB] FAIL s3_len got=%0d want=%0d", t - t_rise, FLASH_LEN);
                end
            end
            prev = lit_s;
            if (t == 15) begin
                checks++;
                if (pend_s !== 2'd3 || ovf_s !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL s3_saturate pending=%0d ovf=%b want 3/0", pend_s, ovf_s);
                end
            end
            if (t == 16) begin
                checks++;
                if (pend_s !== 2'd3 || ovf_s !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL s3_drop pending=%0d ovf=%b want 3/1", pend_s, ovf_s);
                end
            end
            if (t == 23) begin
                checks++;
                if (pend_s !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL s3_replay got=%0d want=2", pend_s);
                end
            end
            if (t == 63) begin
                checks++;
                if (ovf_s !== 1'b1 || busy_s !== 1'b0 || pend_s !== '0) begin
                    failures++;
                    $display("[TB] FAIL s3_end ovf=%b busy=%b pending=%0d want 1/0/0",
                             ovf_s, busy_s, pend_s);
                end
            end
        end
        checks++;
        if (exp_start.size() != 0) begin
            failures++;
            $display("[TB] FAIL s3_count missing=%0d want=0", exp_start.size());
        end
    endtask

    task automatic test_back_to_back();
        int   t_rise;
        int   want;
        int   n_ev;
        logic prev;
        logic ev;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            exp_start.delete();
            prev   = 1'b0;
            t_rise = 0;
            n_ev   = 0;
            for (int t = 0; t < 52; t++) begin
                ev = (t == 10) || (t == 22) || (v == 1 && t == 12);
                drive_cycle(ev);
                if (ev) begin
                    exp_start.push_back(11 + n_ev * PERIOD);
                    n_ev++;
                end
                if (lit_s === 1'b1 && prev !== 1'b1) begin
                    checks++;
                    if (exp_start.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL s4_start v=%0d unexpected flash at t=%0d", v, t);
                    end else begin
                        want = exp_start.pop_front();
                        if (t !== want) begin
                            failures++;
                            $display("[TB] FAIL s4_start v=%0d got=%0d want=%0d", v, t, want);
                        end
                    end
                    t_rise = t;
                end
                if (lit_s !== 1'b1 && prev === 1'b1) begin
                    checks++;
                    if (t - t_rise !== FLASH_LEN) begin
                        failures++;
                        $display("[TB] FAIL s4_len v=%0d got=%0d want=%0d", v, t - t_rise, FLASH_LEN);
                    end
                end
                prev = lit_s;
                if (t == 23) begin
                    checks++;
                    if (pend_s !== CNT_W'(v)) begin
                        failures++;
                        $display("[TB] FAIL s4_pending v=%0d got=%0d want=%0d", v, pend_s, v);
                    end
                end
                if (t == 34 + PERIOD * v) begin
                    checks++;
                    if (busy_s !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL s4_busy_gap v=%0d got=%b want=1", v, busy_s);
                    end
                end
                if (t == 35 + PERIOD * v) begin
                    checks++;
                    if (busy_s !== 1'b0 || pend_s !== '0) begin
                        failures++;
                        $display("[TB] FAIL s4_end v=%0d busy=%b pending=%0d want 0/0", v, busy_s, pend_s);
                    end
                end
            end
            checks++;
            if (exp_start.size() != 0) begin
                failures++;
                $display("[TB] FAIL s4_count v=%0d missing=%0d want=0", v, exp_start.size());
            end
        end
    endtask

    task automatic test_reset_mid_flash();
        int   lit_after;
        logic ev;
        do_reset();
        lit_after = 0;
        for (int t = 0; t < 50; t++) begin
            ev = (t == 10) || (t == 12) || (t == 14);
            drive_cycle(ev);
            if (t == 11) begin
                checks++;
                if (lit_s !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL s5_lit got=%b want=1", lit_s);
                end
            end
            if (t == 15) begin
                checks++;
                if (pend_s !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL s5_pending_pre got=%0d want=2", pend_s);
                end
            end
            if (t == 16) reset = 1'b1;
            if (t == 17) begin
                checks++;
                if (bus.led_out !== LED_DARK || busy_s !== 1'b0 || pend_s !== '0 || ovf_s !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL s5_abort led=%b busy=%b pending=%0d ovf=%b want %b/0/0/0",
                             bus.led_out, busy_s, pend_s, ovf_s, LED_DARK);
                end
                reset = 1'b0;
            end
            if (t > 17 && lit_s !== 1'b0) lit_after++;
        end
        checks++;
        if (lit_after != 0) begin
            failures++;
            $display("[TB] FAIL s5_no_replay lit_cycles=%0d want=0", lit_after);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.event_in = 1'b0;
        $display("[TB] start");
        test_reset();
        test_single_pulse();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_reset_mid_flash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
